// File: rtl/fs_syscall_bridge.sv
`default_nettype none
// ============================================================================
// Module      : fs_syscall_bridge
// Description : Multi-channel filesystem syscall bridge. Round-robin picks one
//               client request, forwards it to the HPS mailbox over a
//               start/done handshake, and returns the result (or a timeout
//               error) to the originating channel.
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module fs_syscall_bridge #(
  parameter int CHANNELS       = 2,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       CLOCK_50,
  input  logic                       reset_n,
  input  logic [CHANNELS-1:0]        req_valid,
  output logic [CHANNELS-1:0]        req_ready,
  input  logic [CHANNELS*8-1:0]      req_syscall,
  input  logic [CHANNELS*DATA_W-1:0] req_arg0,
  input  logic [CHANNELS*DATA_W-1:0] req_arg1,
  input  logic [CHANNELS*DATA_W-1:0] req_arg2,
  output logic [CHANNELS-1:0]        resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       resp_error,
  output logic                       hps_start,
  output logic [7:0]                 hps_syscall,
  output logic [DATA_W-1:0]          hps_arg0,
  output logic [DATA_W-1:0]          hps_arg1,
  output logic [DATA_W-1:0]          hps_arg2,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] hps_channel,
  input  logic                       hps_done,
  input  logic [DATA_W-1:0]          hps_result,
  input  logic                       hps_error,
  output logic                       busy,
  output logic [15:0]                timeout_count
);

  localparam int          CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam bit          c_TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GRANT    = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_LOW = 3'd3,
    S_RESPOND  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_ptr;
  logic [31:0]       r_cnt;
  logic              w_found;
  logic [CH_W-1:0]   w_winner;
  logic [CH_W-1:0]   w_ptr_nxt;
  logic [7:0]        w_sel_sys;
  logic [DATA_W-1:0] w_sel_a0;
  logic [DATA_W-1:0] w_sel_a1;
  logic [DATA_W-1:0] w_sel_a2;
  logic              w_tmo;

  // Round-robin search: first pass covers channels at/above the pointer,
  // second pass wraps around to the channels below it.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!w_found && req_valid[i] && (CH_W'(i) >= r_ptr)) begin
        w_found  = 1'b1;
        w_winner = CH_W'(i);
      end
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (!w_found && req_valid[i] && (CH_W'(i) < r_ptr)) begin
        w_found  = 1'b1;
        w_winner = CH_W'(i);
      end
    end
  end

  // Mux the winning channel's syscall id and arguments.
  always_comb begin
    w_sel_sys = '0;
    w_sel_a0  = '0;
    w_sel_a1  = '0;
    w_sel_a2  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (CH_W'(i) == w_winner) begin
        w_sel_sys = req_syscall[i*8 +: 8];
        w_sel_a0  = req_arg0[i*DATA_W +: DATA_W];
        w_sel_a1  = req_arg1[i*DATA_W +: DATA_W];
        w_sel_a2  = req_arg2[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ptr_nxt = (w_winner == CH_W'(CHANNELS - 1)) ? '0 : w_winner + 1'b1;
  assign w_tmo     = c_TMO_EN && (r_cnt == c_TMO_LAST);

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    resp_valid  = '0;
    hps_start   = 1'b0;
    busy        = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (|req_valid) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        // A request withdrawn before acceptance leaves nothing to issue.
        if (w_found) begin
          req_ready   = CHANNELS'(1) << w_winner;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        hps_start = 1'b1;
        // Completion takes priority over a timeout on the same cycle.
        if (hps_done)   w_state_nxt = S_WAIT_LOW;
        else if (w_tmo) w_state_nxt = S_RESPOND;
      end
      S_WAIT_LOW: begin
        // Wait for a stretched done pulse to end before responding.
        if (!hps_done) w_state_nxt = S_RESPOND;
      end
      S_RESPOND: begin
        resp_valid  = CHANNELS'(1) << hps_channel;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latch, pointer, timeout counter and response capture.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr         <= '0;
      r_cnt         <= '0;
      hps_syscall   <= '0;
      hps_arg0      <= '0;
      hps_arg1      <= '0;
      hps_arg2      <= '0;
      hps_channel   <= '0;
      resp_data     <= '0;
      resp_error    <= 1'b0;
      timeout_count <= '0;
    end else begin
      unique case (r_state)
        S_GRANT: begin
          r_cnt <= '0;
          if (w_found) begin
            hps_syscall <= w_sel_sys;
            hps_arg0    <= w_sel_a0;
            hps_arg1    <= w_sel_a1;
            hps_arg2    <= w_sel_a2;
            hps_channel <= w_winner;
            r_ptr       <= w_ptr_nxt;
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + 32'd1;
          if (hps_done) begin
            resp_data  <= hps_result;
            resp_error <= hps_error;
          end else if (w_tmo) begin
            resp_data  <= '1;
            resp_error <= 1'b1;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fs_syscall_bridge.md
Name: fs_syscall_bridge

Overview:
- Multi-channel successor to the single-port filesystem/HPS bridge.
- Accepts filesystem syscall requests from CHANNELS independent clients (CPU core, swap engine, DMA, ...).
- Arbitrates round-robin and issues one request at a time to the HPS mailbox through a start/done handshake.
- Routes the result back to the originating channel, with a per-request timeout and error reporting.

Parameters:
- CHANNELS, 2: number of client channels, 1..8.
- DATA_W, 32: width of argument and result words.
- TIMEOUT_CYCLES, 65535: cycles allowed between hps_start rising and hps_done; 0 disables the timeout.
- CH_W, $clog2(CHANNELS) (min 1): channel index width, derived, not overridden.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  CHANNELS  per-channel request pending; held until accepted.
- req_ready  out  CHANNELS  one-hot, 1-cycle accept pulse.
- req_syscall  in  CHANNELS*8  per-channel syscall id; channel i in bits [8i+7:8i].
- req_arg0  in  CHANNELS*DATA_W  per-channel path pointer / file descriptor.
- req_arg1  in  CHANNELS*DATA_W  per-channel second pointer / file address.
- req_arg2  in  CHANNELS*DATA_W  per-channel write data.
- resp_valid  out  CHANNELS  one-hot, 1-cycle response strobe.
- resp_data  out  DATA_W  result word, valid when any resp_valid bit is high.
- resp_error  out  1  response is an error (HPS error or timeout).
- hps_start  out  1  level; high while a request is outstanding to the HPS.
- hps_syscall  out  8  latched syscall id.
- hps_arg0, hps_arg1, hps_arg2  out  DATA_W each  latched arguments.
- hps_channel  out  CH_W  originating channel index.
- hps_done  in  1  HPS completion pulse (may last more than one cycle).
- hps_result  in  DATA_W  sampled on the cycle hps_done is first seen high.
- hps_error  in  1  sampled with hps_result.
- busy  out  1  high in any state other than IDLE.
- timeout_count  out  16  saturating count of timed-out requests.

Behaviour:
- Reset (async assert, sync release) sets:
  - all outputs to 0;
  - state IDLE;
  - round-robin pointer to channel 0;
  - timeout counter to 0;
  - timeout_count to 0.
- States:
  - IDLE -> GRANT: when any req_valid is high.
  - GRANT -> ISSUE: after latching the winning channel's syscall/args into hps_* regs and driving req_ready[winner]=1 for this single cycle.
  - ISSUE: hps_start=1; cycle counter increments each cycle.
  - ISSUE -> WAIT_LOW: on the first cycle hps_done=1. hps_result and hps_error are captured into resp_data and resp_error; hps_start drops to 0.
  - ISSUE -> RESPOND (timeout): when TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES, before hps_done. resp_data=all ones, resp_error=1, timeout_count+1 (saturates at 16'hFFFF), hps_start drops to 0.
  - WAIT_LOW -> RESPOND: when hps_done=0. This guards against a multi-cycle done pulse being taken as the next completion.
  - RESPOND -> IDLE: resp_valid[hps_channel]=1 for exactly one cycle.
- Arbitration: the winner is the first channel with req_valid=1, searching from the pointer upward and wrapping past CHANNELS-1. On grant the pointer becomes winner+1 mod CHANNELS.
- Latency: minimum 5 cycles from req_valid rising (IDLE) to resp_valid, with hps_done returned one cycle after hps_start.
- req_valid dropped before acceptance is legal; that request is simply not granted.
- Args are sampled only in GRANT. Later changes on the req_* inputs do not affect the outstanding request.
- hps_done while IDLE, GRANT, WAIT_LOW or RESPOND is ignored and produces no response.
- hps_done on the same cycle the timeout is reached: done wins (normal response, no timeout).
- A late hps_done after a timeout falls into IDLE/GRANT and is ignored.
- resp_data and resp_error hold their values until the next capture. hps_* argument outputs hold their values until the next grant.
- Reset asserted mid-request: immediate return to IDLE; hps_start=0; no response emitted; the outstanding request is lost.
- CHANNELS=1: pointer constant 0; the arbiter degenerates to a pass-through.

Test Plan:
- Single request: ch0 syscall=8'h03, arg0=32'h1000, HPS done with result 32'h7 after 3 cycles -> req_ready[0] pulses once; hps_start high for exactly 4 cycles; resp_valid[0] one cycle with resp_data=32'h7, resp_error=0.
- Round-robin: ch0 and ch1 both valid continuously, HPS always completes -> grants alternate 0,1,0,1; hps_channel matches each grant; no channel is starved.
- Timeout: TIMEOUT_CYCLES=10, hps_done never asserted -> hps_start drops after 10 cycles; resp_valid pulses on the requester with resp_data=32'hFFFFFFFF, resp_error=1; timeout_count=1.
- Long done: hps_done held high for 5 cycles -> exactly one resp_valid; the next request is not issued until hps_done falls.
- Error path: hps_error=1 with hps_result=32'hFFFFFFFE -> resp_error=1, resp_data=32'hFFFFFFFE; timeout_count unchanged.
- Reset mid-ISSUE: reset_n low during hps_start=1 -> hps_start=0 and busy=0 asynchronously; no resp_valid; after release a new ch1 request is granted normally.
